// File: rtl/icache_refill_ctrl.sv
// Instruction-cache line refill controller.
// Fetches the missing 4-word line over a word-wide valid handshake,
// writes it into the cache in one cycle and stalls fetch meanwhile.
module icache_refill_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              miss,
  input  logic [31:0]       miss_addr,
  output logic              mem_req,
  output logic [31:0]       mem_addr,
  input  logic              mem_valid,
  input  logic [31:0]       mem_rdata,
  output logic              line_wr,
  output logic [27:0]       line_addr,
  output logic [127:0]      line_data,
  output logic              stall,
  output logic              err,
  output logic [CNT_W-1:0]  refill_cnt
);

  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, FILL, WRITE, SETTLE} state_t;

  state_t           state;
  state_t           state_next;
  logic [1:0]       beat;
  logic [TMO_W-1:0] tmo_cnt;

  // The low PC bits only select a word inside the line, which the
  // whole-line fetch covers anyway.
  logic unused_offset;
  assign unused_offset = ^miss_addr[3:0];

  // The word being requested always follows the beat index.
  assign mem_addr = {line_addr, beat, 2'b00};

  // State register; reset returns to IDLE from anywhere, dropping a partial line.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs; the stall is raised in the miss cycle itself.
  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    line_wr    = 1'b0;
    stall      = 1'b1;
    case (state)
      IDLE: begin
        stall = miss;
        if (miss) begin
          state_next = FILL;
        end
      end
      FILL: begin
        mem_req = 1'b1;
        if (mem_valid && (beat == 2'd3)) begin
          state_next = WRITE;
        end
      end
      WRITE: begin
        line_wr    = 1'b1;
        state_next = SETTLE;
      end
      SETTLE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Line assembly, timeout restart, sticky error and saturating refill count.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      beat       <= 2'd0;
      tmo_cnt    <= '0;
      err        <= 1'b0;
      refill_cnt <= '0;
      line_addr  <= '0;
      line_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (miss) begin
            line_addr <= miss_addr[31:4];
            line_data <= '0;
            beat      <= 2'd0;
            tmo_cnt   <= '0;
          end
        end
        FILL: begin
          if (mem_valid) begin
            line_data[{beat, 5'd0} +: 32] <= mem_rdata;
            beat    <= beat + 2'd1;
            tmo_cnt <= '0;
          end else if (tmo_cnt == TMO_LAST) begin
            err       <= 1'b1;
            beat      <= 2'd0;
            tmo_cnt   <= '0;
            line_data <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        WRITE: begin
          if (refill_cnt != '1) begin
            refill_cnt <= refill_cnt + CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Self-checking bench for icache_refill_ctrl: randomized refills against a
// cycle-level model of the refill protocol.
module tb_icache_refill_ctrl;

  localparam int TB_TIMEOUT = 4;
  localparam int TB_CNT_W   = 2;
  localparam int CNT_MAX    = (1 << TB_CNT_W) - 1;

  logic                Clk = 1'b0;
  logic                Reset;
  logic                miss;
  logic [31:0]         miss_addr;
  logic                mem_req;
  logic [31:0]         mem_addr;
  logic                mem_valid;
  logic [31:0]         mem_rdata;
  logic                line_wr;
  logic [27:0]         line_addr;
  logic [127:0]        line_data;
  logic                stall;
  logic                err;
  logic [TB_CNT_W-1:0] refill_cnt;

  int checks = 0;
  int errors = 0;

  int           exp_cnt;
  logic         exp_err;
  logic [27:0]  exp_line_addr;
  logic [127:0] exp_line_data;
  logic [31:0]  line_words [4];

  icache_refill_ctrl #(.TIMEOUT(TB_TIMEOUT), .CNT_W(TB_CNT_W)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .miss       (miss),
    .miss_addr  (miss_addr),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_valid  (mem_valid),
    .mem_rdata  (mem_rdata),
    .line_wr    (line_wr),
    .line_addr  (line_addr),
    .line_data  (line_data),
    .stall      (stall),
    .err        (err),
    .refill_cnt (refill_cnt)
  );

  // Free-running clock.
  always #5 Clk = ~Clk;

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic m, input logic [31:0] ma,
                               input logic v, input logic [31:0] d);
    Reset     = rst;
    miss      = m;
    miss_addr = ma;
    mem_valid = v;
    mem_rdata = d;
  endtask

  task automatic nextCycle();
    @(posedge Clk);
    #1;
  endtask

  // One quiet IDLE cycle: no stall, no request, last line held.
  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, $urandom, 1'($urandom), $urandom);
    @(negedge Clk);
    checkOutput("idle_stall", stall, 0);
    checkOutput("idle_req", mem_req, 0);
    checkOutput("idle_wr", line_wr, 0);
    checkOutput("idle_err", err, exp_err);
    checkOutput("idle_laddr", line_addr, exp_line_addr);
    checkOutput("idle_ldata", line_data, exp_line_data);
    nextCycle();
  endtask

  // mode 0: zero wait, 1: three waits per beat, 2: random waits,
  // 3: k beats then silence until timeout, then a clean zero-wait line.
  task automatic runRefill(input logic [31:0] addr, input int mode, input int k);
    bit   q[$];
    int   qlen;
    int   acc;
    int   empty;
    int   cyc;
    bit   done;
    bit   v;
    logic [27:0] la;
    la = addr[31:4];
    case (mode)
      0: repeat (4) q.push_back(1'b1);
      1: repeat (4) begin repeat (3) q.push_back(1'b0); q.push_back(1'b1); end
      2: repeat (4) begin
           repeat ($urandom_range(0, TB_TIMEOUT - 1)) q.push_back(1'b0);
           q.push_back(1'b1);
         end
      default: begin
        repeat (k) q.push_back(1'b1);
        repeat (TB_TIMEOUT) q.push_back(1'b0);
        repeat (4) q.push_back(1'b1);
      end
    endcase
    qlen = q.size();

    applyStimulus(1'b0, 1'b1, addr, 1'($urandom), $urandom);
    @(negedge Clk);
    checkOutput("miss_stall", stall, 1);
    checkOutput("miss_req", mem_req, 0);
    checkOutput("miss_wr", line_wr, 0);
    nextCycle();

    acc = 0; empty = 0; cyc = 1; done = 0;
    while (!done) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL fill_bound observed=beats_%0d expected=line_complete", acc);
        break;
      end
      v = q.pop_front();
      applyStimulus(1'b0, 1'($urandom), $urandom, v, v ? line_words[acc] : $urandom);
      @(negedge Clk);
      checkOutput("fill_req", mem_req, 1);
      checkOutput("fill_stall", stall, 1);
      checkOutput("fill_wr", line_wr, 0);
      checkOutput("fill_addr", mem_addr, {la, 2'(acc), 2'b00});
      checkOutput("fill_laddr", line_addr, la);
      checkOutput("fill_err", err, exp_err);
      if (v) begin
        acc++;
        empty = 0;
        if (acc == 4) done = 1;
      end else begin
        empty++;
        if (empty == TB_TIMEOUT) begin
          exp_err = 1'b1;
          acc     = 0;
          empty   = 0;
        end
      end
      nextCycle();
      cyc++;
    end

    exp_line_addr = la;
    exp_line_data = {line_words[3], line_words[2], line_words[1], line_words[0]};
    applyStimulus(1'b0, 1'b1, $urandom, 1'($urandom), $urandom);
    @(negedge Clk);
    checkOutput("wr_cycle", cyc, qlen + 1);
    checkOutput("wr_strobe", line_wr, 1);
    checkOutput("wr_stall", stall, 1);
    checkOutput("wr_req", mem_req, 0);
    checkOutput("wr_laddr", line_addr, exp_line_addr);
    checkOutput("wr_ldata", line_data, exp_line_data);
    checkOutput("wr_cnt_old", refill_cnt, exp_cnt);
    exp_cnt = (exp_cnt < CNT_MAX) ? exp_cnt + 1 : exp_cnt;
    nextCycle();

    applyStimulus(1'b0, 1'b1, $urandom, 1'($urandom), $urandom);
    @(negedge Clk);
    checkOutput("settle_stall", stall, 1);
    checkOutput("settle_wr", line_wr, 0);
    checkOutput("settle_req", mem_req, 0);
    checkOutput("settle_cnt", refill_cnt, exp_cnt);
    checkOutput("settle_err", err, exp_err);
    checkOutput("settle_laddr", line_addr, exp_line_addr);
    nextCycle();
  endtask

  // Abort a refill with reset after two beats; nothing of it may be written.
  task automatic resetMidFill();
    logic [31:0] a;
    a = $urandom;
    applyStimulus(1'b0, 1'b1, a, 1'b0, 32'h0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, $urandom, 1'b1, $urandom);
    nextCycle();
    applyStimulus(1'b0, 1'b0, $urandom, 1'b1, $urandom);
    nextCycle();
    applyStimulus(1'b1, 1'b0, $urandom, 1'b1, $urandom);
    nextCycle();
    exp_cnt = 0; exp_err = 1'b0; exp_line_addr = '0; exp_line_data = '0;
    applyStimulus(1'b1, 1'b1, $urandom, 1'b1, $urandom);
    @(negedge Clk);
    checkOutput("rst_stall_miss", stall, 1);
    checkOutput("rst_req", mem_req, 0);
    checkOutput("rst_wr", line_wr, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_cnt", refill_cnt, 0);
    checkOutput("rst_laddr", line_addr, 0);
    checkOutput("rst_ldata", line_data, 0);
    nextCycle();
    repeat (3) idleCycle();
  endtask

  // Directed scenarios first, then randomized refills.
  initial begin
    exp_cnt = 0; exp_err = 1'b0; exp_line_addr = '0; exp_line_data = '0;
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    nextCycle();
    @(negedge Clk);
    checkOutput("init_req", mem_req, 0);
    checkOutput("init_wr", line_wr, 0);
    checkOutput("init_stall", stall, 0);
    checkOutput("init_err", err, 0);
    checkOutput("init_cnt", refill_cnt, 0);
    checkOutput("init_laddr", line_addr, 0);
    checkOutput("init_ldata", line_data, 0);
    nextCycle();
    idleCycle();

    line_words[0] = 32'hA0; line_words[1] = 32'hA1;
    line_words[2] = 32'hA2; line_words[3] = 32'hA3;
    runRefill(32'h0000_0104, 0, 0);
    idleCycle();
    runRefill(32'h0000_0104, 1, 0);
    idleCycle();

    for (int i = 0; i < 4; i++) line_words[i] = $urandom;
    runRefill($urandom, 3, 1);
    idleCycle();

    for (int n = 0; n < 2; n++) begin
      for (int i = 0; i < 4; i++) line_words[i] = $urandom;
      runRefill($urandom, 0, 0);
    end
    idleCycle();

    resetMidFill();
    for (int i = 0; i < 4; i++) line_words[i] = $urandom;
    runRefill($urandom, 0, 0);
    idleCycle();

    for (int n = 0; n < 10; n++) begin
      int m;
      m = $urandom_range(0, 3);
      for (int i = 0; i < 4; i++) line_words[i] = $urandom;
      runRefill($urandom, (m == 1) ? 2 : m, $urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) idleCycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
